// File: rtl/gate_test_sequencer.sv
// rtl/gate_test_sequencer.sv - sweeps every input vector of a combinational gate and checks it against GATE_OP.
// Optional: define GATE_SEQ_STOP_ON_FAIL_EN to end the sweep at the first mismatch.
module gate_test_sequencer #(
  parameter int                N_IN        = 2,
  parameter logic [2**N_IN-1:0] GATE_OP     = 4'b1000,
  parameter int                HOLD_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] dut_a,
  input  logic            dut_y,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] fail_vec
);

  localparam int NV     = 2**N_IN;
  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DRIVE  = 2'd1;
  localparam logic [1:0] SAMPLE = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [N_IN-1:0]   VEC_LAST  = N_IN'(NV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [N_IN:0]     ERR_MAX   = (N_IN + 1)'(NV);

  logic [1:0]        state;
  logic [N_IN-1:0]   vec;
  logic [HOLD_W-1:0] hold;
  logic              mismatch;
  logic              stop_now;

  // The vector counter is the gate input register; it only moves on SAMPLE->DRIVE.
  assign dut_a    = vec;
  assign busy     = (state != IDLE);
  assign mismatch = (dut_y != GATE_OP[vec]);

`ifdef GATE_SEQ_STOP_ON_FAIL_EN
  assign stop_now = mismatch;
`else
  assign stop_now = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      vec       <= '0;
      hold      <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vec  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= DRIVE;
            vec       <= '0;
            hold      <= '0;
            err_count <= '0;
            fail_vec  <= '0;
            pass      <= 1'b0;
          end
        end
        DRIVE: begin
          if (hold == HOLD_LAST) begin
            state <= SAMPLE;
          end else begin
            hold <= hold + 1'b1;
          end
        end
        SAMPLE: begin
          if (mismatch) begin
            if (err_count != ERR_MAX) begin
              err_count <= err_count + 1'b1;
            end
            if (err_count == '0) begin
              fail_vec <= vec;
            end
          end
          if (vec == VEC_LAST || stop_now) begin
            state <= DONE;
          end else begin
            vec   <= vec + 1'b1;
            hold  <= '0;
            state <= DRIVE;
          end
        end
        DONE: begin
          done  <= 1'b1;
          pass  <= (err_count == '0);
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_test_sequencer.sv
// tb/tb_gate_test_sequencer.sv - randomized truth-table sweeps of gate_test_sequencer against a reference model.
module tb_gate_test_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Main instance: 2-input, expects AND, hold 4. Gate is a programmable table.
  logic       start1 = 1'b0;
  logic [1:0] a1;
  logic       y1;
  logic       busy1, done1, pass1;
  logic [2:0] err1;
  logic [1:0] fv1;
  logic [3:0] gate_tbl = 4'b1000;
  assign y1 = gate_tbl[a1];

  gate_test_sequencer #(.N_IN(2), .GATE_OP(4'b1000), .HOLD_CYCLES(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .dut_a(a1), .dut_y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_vec(fv1)
  );

  // NOT gate instance.
  logic       start2 = 1'b0;
  logic [0:0] a2;
  logic       y2;
  logic       busy2, done2, pass2;
  logic [1:0] err2;
  logic [0:0] fv2;
  assign y2 = ~a2[0];

  gate_test_sequencer #(.N_IN(1), .GATE_OP(2'b01), .HOLD_CYCLES(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .dut_a(a2), .dut_y(y2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .fail_vec(fv2)
  );

  // Hold-1 AND instance for back-to-back sweeps.
  logic       start3 = 1'b0;
  logic [1:0] a3;
  logic       y3;
  logic       busy3, done3, pass3;
  logic [2:0] err3;
  logic [1:0] fv3;
  assign y3 = &a3;

  gate_test_sequencer #(.N_IN(2), .GATE_OP(4'b1000), .HOLD_CYCLES(1)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .dut_a(a3), .dut_y(y3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3), .fail_vec(fv3)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_total++; if ({a1, busy1, done1, pass1, err1, fv1} !== 10'd0) $display("FAIL reset_dut1: got %b expected 0", {a1, busy1, done1, pass1, err1, fv1}); else n_pass++;
    n_total++; if ({a2, busy2, done2, pass2, err2, fv2} !== 7'd0) $display("FAIL reset_dut2: got %b expected 0", {a2, busy2, done2, pass2, err2, fv2}); else n_pass++;
    n_total++; if ({a3, busy3, done3, pass3, err3, fv3} !== 10'd0) $display("FAIL reset_dut3: got %b expected 0", {a3, busy3, done3, pass3, err3, fv3}); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Reference: mismatches are the set bits of (table ^ GATE_OP); the sweep visits
  // vectors in ascending order, HOLD+1 cycles each, and done follows one cycle after DONE.
  task automatic sweep1(input logic [3:0] tbl, input string tag, input bit do_abort);
    logic [3:0] mism;
    int exp_err, exp_fv, last_vec, done_edge, v;
    mism = tbl ^ 4'b1000;
    exp_err = 0;
    exp_fv = 0;
    for (int i = 3; i >= 0; i--) begin
      if (mism[i]) begin
        exp_err++;
        exp_fv = i;
      end
    end
    last_vec = 3;
`ifdef GATE_SEQ_STOP_ON_FAIL_EN
    if (exp_err != 0) begin
      exp_err = 1;
      last_vec = exp_fv;
    end
`endif
    done_edge = (last_vec + 1) * 5 + 1;
    gate_tbl = tbl;
    @(negedge clk);
    start1 = 1'b1;
    @(posedge clk);
    #1;
    start1 = 1'b0;
    for (int k = 0; k <= done_edge; k++) begin
      v = k / 5;
      if (v > last_vec) v = last_vec;
      n_total++; if (a1 !== 2'(v)) $display("FAIL %s dut_a@%0d: got %0d expected %0d", tag, k, a1, v); else n_pass++;
      n_total++; if (busy1 !== (k < done_edge)) $display("FAIL %s busy@%0d: got %b expected %b", tag, k, busy1, (k < done_edge)); else n_pass++;
      n_total++; if (done1 !== (k == done_edge)) $display("FAIL %s done@%0d: got %b expected %b", tag, k, done1, (k == done_edge)); else n_pass++;
      if (do_abort && k == 7) start1 = 1'b1;
      if (do_abort && k == 8) start1 = 1'b0;
      if (do_abort && k == 12) begin
        #2;
        rst_n = 1'b0;
        #1;
        n_total++; if ({a1, busy1, done1, pass1, err1, fv1} !== 10'd0) $display("FAIL %s async_reset: got %b expected 0", tag, {a1, busy1, done1, pass1, err1, fv1}); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (k == done_edge) begin
        n_total++; if (pass1 !== (exp_err == 0)) $display("FAIL %s pass: got %b expected %b", tag, pass1, (exp_err == 0)); else n_pass++;
        n_total++; if (err1 !== 3'(exp_err)) $display("FAIL %s err_count: got %0d expected %0d", tag, err1, exp_err); else n_pass++;
        if (exp_err != 0) begin
          n_total++; if (fv1 !== 2'(exp_fv)) $display("FAIL %s fail_vec: got %0d expected %0d", tag, fv1, exp_fv); else n_pass++;
        end
      end else begin
        @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    #1;
    n_total++; if (done1 !== 1'b0) $display("FAIL %s done_pulse_width: got %b expected 0", tag, done1); else n_pass++;
  endtask

  task automatic test_and_sweep();
    sweep1(4'b1000, "and_ok", 1'b0);
  endtask

  task automatic test_stuck_zero();
    sweep1(4'b0000, "stuck0", 1'b0);
  endtask

  task automatic test_or_gate();
    sweep1(4'b1110, "or_gate", 1'b0);
  endtask

  task automatic test_random_tables();
    for (int i = 0; i < 8; i++) begin
      sweep1(4'($urandom_range(0, 15)), $sformatf("rand%0d", i), 1'b0);
    end
  endtask

  task automatic test_restart_and_reset();
    sweep1(4'b1000, "abort", 1'b1);
    @(negedge clk);
    n_total++; if (busy1 !== 1'b0) $display("FAIL post_reset_idle busy: got %b expected 0", busy1); else n_pass++;
    sweep1(4'b1000, "restart", 1'b0);
  endtask

  task automatic test_not_gate();
    @(negedge clk);
    start2 = 1'b1;
    @(posedge clk);
    #1;
    start2 = 1'b0;
    for (int k = 0; k <= 11; k++) begin
      n_total++; if (a2 !== 1'((k >= 5) ? 1 : 0)) $display("FAIL not dut_a@%0d: got %0d expected %0d", k, a2, (k >= 5)); else n_pass++;
      n_total++; if (done2 !== (k == 11)) $display("FAIL not done@%0d: got %b expected %b", k, done2, (k == 11)); else n_pass++;
      if (k < 11) begin
        @(posedge clk);
        #1;
      end
    end
    n_total++; if (pass2 !== 1'b1) $display("FAIL not pass: got %b expected 1", pass2); else n_pass++;
    n_total++; if (err2 !== 2'd0) $display("FAIL not err_count: got %0d expected 0", err2); else n_pass++;
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    start3 = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k <= 29; k++) begin
      n_total++; if (done3 !== (k % 10 == 9)) $display("FAIL b2b done@%0d: got %b expected %b", k, done3, (k % 10 == 9)); else n_pass++;
      n_total++; if (busy3 !== (k % 10 != 9)) $display("FAIL b2b busy@%0d: got %b expected %b", k, busy3, (k % 10 != 9)); else n_pass++;
      if (k % 10 == 9) begin
        n_total++; if (pass3 !== 1'b1) $display("FAIL b2b pass@%0d: got %b expected 1", k, pass3); else n_pass++;
      end
      if (k == 29) start3 = 1'b0;
      else begin
        @(posedge clk);
        #1;
      end
    end
    @(posedge clk);
    #1;
    n_total++; if (busy3 !== 1'b0) $display("FAIL b2b stop busy: got %b expected 0", busy3); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_and_sweep();
    test_not_gate();
    test_stuck_zero();
    test_or_gate();
    test_restart_and_reset();
    test_random_tables();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
